pingpong_step_decoder: RTL

- Receive side of the 3-bit bouncing colour-step counter: samples its 3-bit value in the pixel clock domain and reconstructs each step as a one-cycle event.
- Tracks sweep direction and counts completed 0→7→0 sweeps.
- Flags any value sequence that breaks the ping-pong pattern: illegal jumps, and reversals away from the bounds.
- Sits between the enable-clocked counter and the colour/pattern logic of the VGA controller.

---
 rtl/pingpong_step_decoder.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/pingpong_step_decoder.sv
// ---------------------------------------------------------------------------
// pingpong_step_decoder
//
// Receive side of the 3-bit bouncing colour-step counter. The counter value
// is sampled in the pixel clock domain and each accepted change becomes a
// one-cycle step event. The block tracks the sweep direction, counts
// completed 0->7->0 sweeps and flags values that break the ping-pong pattern.
//
// Build option:
//   PPDEC_SYNC_EN  defined   : in_num passes through a two-flop synchronizer
//                              first, so results appear two edges later.
//                  undefined : in_num is compared directly. The source must
//                              be synchronous to clk.
//
// Parameters:
//   SWEEP_W     width of the completed-sweep counter (default 8)
//
// Ports:
//   clk         pixel clock, rising edge
//   reset       asynchronous, active-high reset
//   in_num      counter value from the step source
//   clr_err     synchronous clear of err_sticky (a new error wins)
//   step        one-cycle pulse per legal step
//   dir         sweep direction, 0 = up, 1 = down
//   cur_num     last value accepted by a legal step
//   at_bound    cur_num is 0 or 7
//   sweep_cnt   completed sweeps, wraps modulo 2^SWEEP_W
//   err         one-cycle pulse on entry to the error/resync state
//   err_sticky  latched violation flag
// ---------------------------------------------------------------------------
module pingpong_step_decoder #(
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         in_num,
  input  logic               clr_err,
  output logic               step,
  output logic               dir,
  output logic [2:0]         cur_num,
  output logic               at_bound,
  output logic [SWEEP_W-1:0] sweep_cnt,
  output logic               err,
  output logic               err_sticky
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // An up step moves one higher and never wraps 7 -> 0.
  function automatic logic is_up_step(input logic [2:0] s, input logic [2:0] p);
    return (p != 3'd7) && (s == (p + 3'd1));
  endfunction

  // A down step moves one lower and never wraps 0 -> 7.
  function automatic logic is_dn_step(input logic [2:0] s, input logic [2:0] p);
    return (p != 3'd0) && (s == (p - 3'd1));
  endfunction

  // Register set
  state_t             state_q,      state_d;
  logic [2:0]         p_q,          p_d;
  logic               dir_q,        dir_d;
  logic [2:0]         cur_num_q,    cur_num_d;
  logic [SWEEP_W-1:0] sweep_cnt_q,  sweep_cnt_d;
  logic               step_q,       step_d;
  logic               err_q,        err_d;
  logic               err_sticky_q, err_sticky_d;

  // Compare-side view of the incoming value
  logic [2:0]         samp_s;
  logic               up_step_s;
  logic               dn_step_s;
  logic               moved_s;

`ifdef PPDEC_SYNC_EN
  // All three bits are synchronized together. A bit-skewed capture during a
  // multi-bit change (e.g. 3 -> 4) shows up as a jump and is handled by the
  // normal resync path; the source spacing rule keeps this rare.
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;

  // Synchronizer shift: in_num -> sync1 -> sync2.
  always_comb begin
    sync1_d = in_num;
    sync2_d = sync1_q;
  end

  // Synchronizer flops, cleared by reset so the first compare sees 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 3'd0;
      sync2_q <= 3'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign samp_s = sync2_q;
`else
  assign samp_s = in_num;
`endif

  assign up_step_s = is_up_step(samp_s, p_q);
  assign dn_step_s = is_dn_step(samp_s, p_q);
  assign moved_s   = (samp_s != p_q);

  // Next-state, accepted-value and event-pulse decode for one compare cycle.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    dir_d       = dir_q;
    cur_num_d   = cur_num_q;
    sweep_cnt_d = sweep_cnt_q;
    step_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      // IDLE only ever holds p = 0, so it shares the UP rules; a down step
      // cannot be recognised from there.
      ST_IDLE, ST_UP: begin
        if (up_step_s) begin
          step_d    = 1'b1;
          p_d       = samp_s;
          cur_num_d = samp_s;
          state_d   = ST_UP;
        end else if (dn_step_s && (p_q == 3'd7)) begin
          // Turn-around at the top bound.
          step_d    = 1'b1;
          p_d       = samp_s;
          cur_num_d = samp_s;
          dir_d     = 1'b1;
          state_d   = ST_DOWN;
        end else if (moved_s) begin
          err_d   = 1'b1;
          p_d     = samp_s;
          state_d = ST_ERR;
        end else begin
          state_d = state_q;
        end
      end

      ST_DOWN: begin
        if (dn_step_s) begin
          step_d    = 1'b1;
          p_d       = samp_s;
          cur_num_d = samp_s;
          state_d   = ST_DOWN;
          // Landing on 0 while descending closes a full sweep.
          if (samp_s == 3'd0) begin
            sweep_cnt_d = sweep_cnt_q + SWEEP_W'(1);
          end else begin
            sweep_cnt_d = sweep_cnt_q;
          end
        end else if (up_step_s && (p_q == 3'd0)) begin
          // Turn-around at the bottom bound.
          step_d    = 1'b1;
          p_d       = samp_s;
          cur_num_d = samp_s;
          dir_d     = 1'b0;
          state_d   = ST_UP;
        end else if (moved_s) begin
          err_d   = 1'b1;
          p_d     = samp_s;
          state_d = ST_ERR;
        end else begin
          state_d = state_q;
        end
      end

      // Resync: follow the input silently until it sits on a bound, which
      // fixes the direction unambiguously. No step pulse on the way out.
      ST_ERR: begin
        p_d = samp_s;
        if (samp_s == 3'd0) begin
          dir_d   = 1'b0;
          state_d = ST_UP;
        end else if (samp_s == 3'd7) begin
          dir_d   = 1'b1;
          state_d = ST_DOWN;
        end else begin
          state_d = ST_ERR;
        end
      end

      default: begin
        p_d     = samp_s;
        state_d = ST_ERR;
      end
    endcase

    // A new error in the same cycle as clr_err keeps the flag set.
    if (err_d) begin
      err_sticky_d = 1'b1;
    end else if (clr_err) begin
      err_sticky_d = 1'b0;
    end else begin
      err_sticky_d = err_sticky_q;
    end
  end

  // FSM state plus all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      p_q          <= 3'd0;
      dir_q        <= 1'b0;
      cur_num_q    <= 3'd0;
      sweep_cnt_q  <= '0;
      step_q       <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      dir_q        <= dir_d;
      cur_num_q    <= cur_num_d;
      sweep_cnt_q  <= sweep_cnt_d;
      step_q       <= step_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign step       = step_q;
  assign dir        = dir_q;
  assign cur_num    = cur_num_q;
  assign at_bound   = (cur_num_q == 3'd0) || (cur_num_q == 3'd7);
  assign sweep_cnt  = sweep_cnt_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;

endmodule
